// File: rtl/line_window_3x3.sv
// line_window_3x3: forms a 3x3 luma neighbourhood from a raster pixel stream.
// Two line buffers hold the previous two lines; a 3-column shift register forms
// the window. Syncs and blank are delayed to stay aligned with the window.
module line_window_3x3 #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_HSYNC,
  input  logic              i_VSYNC,
  input  logic              i_BLANK,
  input  logic [DATA_W-1:0] i_Y0,
  output logic              o_HSYNC,
  output logic              o_VSYNC,
  output logic              o_BLANK,
  output logic [DATA_W-1:0] o_matrix11,
  output logic [DATA_W-1:0] o_matrix12,
  output logic [DATA_W-1:0] o_matrix13,
  output logic [DATA_W-1:0] o_matrix21,
  output logic [DATA_W-1:0] o_matrix22,
  output logic [DATA_W-1:0] o_matrix23,
  output logic [DATA_W-1:0] o_matrix31,
  output logic [DATA_W-1:0] o_matrix32,
  output logic [DATA_W-1:0] o_matrix33
);

  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_W - 1);

  // Column address advances per active pixel and holds at the last RAM address.
  function automatic logic [ADDR_W-1:0] sat_inc_col(input logic [ADDR_W-1:0] c);
    return (c == LAST_COL) ? c : c + 1'b1;
  endfunction

  // Zeroes line-buffer data that belongs to rows above the top of the frame.
  function automatic logic [DATA_W-1:0] mask_line(input logic [DATA_W-1:0] d,
                                                  input logic              keep);
    return keep ? d : '0;
  endfunction

  logic [DATA_W-1:0] lb0_mem [0:IMG_W-1];
  logic [DATA_W-1:0] lb1_mem [0:IMG_W-1];

  logic [ADDR_W-1:0] col_cnt;
  logic              line_full;
  logic [1:0]        row_cnt;

  logic              hsync_p1, vsync_p1, vld_p1;
  logic [DATA_W-1:0] y_p1, lb0_rd_p1, lb1_rd_p1;
  logic [1:0]        row_p1;

  logic              hsync_p2, vsync_p2, vld_p2;
  logic [DATA_W-1:0] w11_p2, w12_p2, w13_p2;
  logic [DATA_W-1:0] w21_p2, w22_p2, w23_p2;
  logic [DATA_W-1:0] w31_p2, w32_p2, w33_p2;

  logic              eol;
  logic              vsync_fall;
  logic [DATA_W-1:0] lb0_m, lb1_m;

  assign eol        = vld_p1 & ~i_BLANK;
  assign vsync_fall = vsync_p1 & ~i_VSYNC;

  // Column counter and the flag that stops writes once the last address is used.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt   <= '0;
      line_full <= 1'b0;
    end else if (!i_BLANK) begin
      col_cnt   <= '0;
      line_full <= 1'b0;
    end else begin
      col_cnt <= sat_inc_col(col_cnt);
      if (col_cnt == LAST_COL) line_full <= 1'b1;
    end
  end

  // Line index within the frame; frame start wins over end of line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt <= '0;
    end else if (vsync_fall) begin
      row_cnt <= '0;
    end else if (eol && row_cnt != 2'd2) begin
      row_cnt <= row_cnt + 2'd1;
    end
  end

  // Line buffers: registered read, read-before-write cascade LB0 -> LB1.
  always_ff @(posedge clk) begin
    if (i_BLANK) begin
      lb0_rd_p1 <= lb0_mem[col_cnt];
      lb1_rd_p1 <= lb1_mem[col_cnt];
      if (!line_full) begin
        lb0_mem[col_cnt] <= i_Y0;
        lb1_mem[col_cnt] <= lb0_mem[col_cnt];
      end
    end
  end

  // ---- stage 1: input pixel, controls and row index aligned with RAM read ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_p1 <= 1'b0;
      vsync_p1 <= 1'b0;
      vld_p1   <= 1'b0;
      y_p1     <= '0;
      row_p1   <= '0;
    end else begin
      hsync_p1 <= i_HSYNC;
      vsync_p1 <= i_VSYNC;
      vld_p1   <= i_BLANK;
      y_p1     <= i_Y0;
      row_p1   <= row_cnt;
    end
  end

  assign lb1_m = mask_line(lb1_rd_p1, row_p1 == 2'd2);
  assign lb0_m = mask_line(lb0_rd_p1, row_p1 != 2'd0);

  // ---- stage 2: window shift on active pixels, clear between lines ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_p2 <= 1'b0;
      vsync_p2 <= 1'b0;
      vld_p2   <= 1'b0;
      w11_p2 <= '0; w12_p2 <= '0; w13_p2 <= '0;
      w21_p2 <= '0; w22_p2 <= '0; w23_p2 <= '0;
      w31_p2 <= '0; w32_p2 <= '0; w33_p2 <= '0;
    end else begin
      hsync_p2 <= hsync_p1;
      vsync_p2 <= vsync_p1;
      vld_p2   <= vld_p1;
      if (vld_p1) begin
        w11_p2 <= w12_p2; w12_p2 <= w13_p2; w13_p2 <= lb1_m;
        w21_p2 <= w22_p2; w22_p2 <= w23_p2; w23_p2 <= lb0_m;
        w31_p2 <= w32_p2; w32_p2 <= w33_p2; w33_p2 <= y_p1;
      end else begin
        w11_p2 <= '0; w12_p2 <= '0; w13_p2 <= '0;
        w21_p2 <= '0; w22_p2 <= '0; w23_p2 <= '0;
        w31_p2 <= '0; w32_p2 <= '0; w33_p2 <= '0;
      end
    end
  end

  assign o_HSYNC    = hsync_p2;
  assign o_VSYNC    = vsync_p2;
  assign o_BLANK    = vld_p2;
  assign o_matrix11 = w11_p2;
  assign o_matrix12 = w12_p2;
  assign o_matrix13 = w13_p2;
  assign o_matrix21 = w21_p2;
  assign o_matrix22 = w22_p2;
  assign o_matrix23 = w23_p2;
  assign o_matrix31 = w31_p2;
  assign o_matrix32 = w32_p2;
  assign o_matrix33 = w33_p2;

endmodule

// File: tb/tb_line_window_3x3.sv
// Directed bench for line_window_3x3 with an 8-pixel line buffer.
module tb_line_window_3x3;

  typedef struct packed {
    logic [7:0] m11, m12, m13, m21, m22, m23, m31, m32, m33;
  } win_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_HSYNC, i_VSYNC, i_BLANK;
  logic [7:0] i_Y0;
  logic       o_HSYNC, o_VSYNC, o_BLANK;
  logic [7:0] o_matrix11, o_matrix12, o_matrix13;
  logic [7:0] o_matrix21, o_matrix22, o_matrix23;
  logic [7:0] o_matrix31, o_matrix32, o_matrix33;

  win_t cur;
  win_t out_q[$];
  int   checks = 0;
  int   errors = 0;
  int   base;

  line_window_3x3 #(.DATA_W(8), .IMG_W(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst),
    .i_HSYNC(i_HSYNC), .i_VSYNC(i_VSYNC), .i_BLANK(i_BLANK), .i_Y0(i_Y0),
    .o_HSYNC(o_HSYNC), .o_VSYNC(o_VSYNC), .o_BLANK(o_BLANK),
    .o_matrix11(o_matrix11), .o_matrix12(o_matrix12), .o_matrix13(o_matrix13),
    .o_matrix21(o_matrix21), .o_matrix22(o_matrix22), .o_matrix23(o_matrix23),
    .o_matrix31(o_matrix31), .o_matrix32(o_matrix32), .o_matrix33(o_matrix33)
  );

  always #5 clk = ~clk;

  assign cur = {o_matrix11, o_matrix12, o_matrix13,
                o_matrix21, o_matrix22, o_matrix23,
                o_matrix31, o_matrix32, o_matrix33};

  // Record every window presented with o_BLANK high, sampled mid-cycle.
  always @(negedge clk) begin
    if (o_BLANK === 1'b1) out_q.push_back(cur);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic win_t mk(input int a, input int b, input int c,
                              input int d, input int e, input int f,
                              input int g, input int h, input int i);
    win_t w;
    w.m11 = 8'(a); w.m12 = 8'(b); w.m13 = 8'(c);
    w.m21 = 8'(d); w.m22 = 8'(e); w.m23 = 8'(f);
    w.m31 = 8'(g); w.m32 = 8'(h); w.m33 = 8'(i);
    return w;
  endfunction

  // Missing outputs read back as all-ones, which no expected window contains.
  function automatic win_t get_w(input int idx);
    if (idx < int'(out_q.size())) return out_q[idx];
    return '1;
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input win_t obs, input win_t exp);
    chk(tag, {8'h00, obs}, {8'h00, exp});
  endtask

  task automatic cyc(input logic hs, input logic vs, input logic bl, input int y);
    i_HSYNC = hs;
    i_VSYNC = vs;
    i_BLANK = bl;
    i_Y0    = 8'(y);
    @(posedge clk);
    #1;
  endtask

  // One line of n pixels first, first+1, ... followed by a 4-cycle blank gap.
  task automatic line(input int first, input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b1, 1'b1, first + k);
    for (int k = 0; k < 4; k++) cyc(k == 1 ? 1'b0 : 1'b1, 1'b1, 1'b0, 0);
  endtask

  task automatic frame_start();
    cyc(1'b1, 1'b0, 1'b0, 0);
    cyc(1'b1, 1'b0, 1'b0, 0);
    cyc(1'b1, 1'b1, 1'b0, 0);
  endtask

  initial begin
    rst = 1'b1;
    i_HSYNC = 1'b0; i_VSYNC = 1'b0; i_BLANK = 1'b0; i_Y0 = 8'h00;

    // Reset held with random inputs: every output stays 0.
    for (int k = 0; k < 6; k++) begin
      i_HSYNC = 1'($urandom); i_VSYNC = 1'($urandom);
      i_BLANK = 1'($urandom); i_Y0 = 8'($urandom);
      @(posedge clk);
      #1;
      chk($sformatf("reset_outputs_%0d", k),
          {5'b0, o_HSYNC, o_VSYNC, o_BLANK, cur}, 80'h0);
    end
    i_HSYNC = 1'b1; i_VSYNC = 1'b1; i_BLANK = 1'b0; i_Y0 = 8'h00;
    rst = 1'b0;

    // Syncs emerge exactly two cycles after they are presented.
    cyc(1'b1, 1'b1, 1'b0, 0);
    chk("sync_delay_1", {77'b0, o_HSYNC, o_VSYNC, o_BLANK}, 80'b000);
    cyc(1'b1, 1'b1, 1'b0, 0);
    chk("sync_delay_2", {77'b0, o_HSYNC, o_VSYNC, o_BLANK}, 80'b110);

    // Frame line 0: pixels 1..8, no rows above.
    frame_start();
    base = int'(out_q.size());
    line(1, 8);
    chk("l0_count", 80'(int'(out_q.size()) - base), 80'd8);
    chk_w("l0_first", get_w(base + 0), mk(0,0,0, 0,0,0, 0,0,1));
    chk_w("l0_third", get_w(base + 2), mk(0,0,0, 0,0,0, 1,2,3));
    for (int k = 0; k < 8; k++) begin
      win_t w;
      w = get_w(base + k);
      chk($sformatf("l0_col3_%0d", k), {56'h0, w.m13, w.m23, w.m33},
          {56'h0, 8'd0, 8'd0, 8'(k + 1)});
    end
    chk("gap_clear", {7'b0, o_BLANK, cur}, 80'h0);

    // Line 1: pixels 9..16, row 2 comes from line 0.
    base = int'(out_q.size());
    line(9, 8);
    chk_w("l1_first", get_w(base + 0), mk(0,0,0, 0,0,1, 0,0,9));
    chk_w("l1_last", get_w(base + 7), mk(0,0,0, 6,7,8, 14,15,16));

    // Line 2: pixels 17..24, full neighbourhood.
    base = int'(out_q.size());
    line(17, 8);
    chk_w("l2_first", get_w(base + 0), mk(0,0,1, 0,0,9, 0,0,17));
    chk_w("l2_fifth", get_w(base + 4), mk(3,4,5, 11,12,13, 19,20,21));

    // New frame: stale lines of the previous frame must stay hidden.
    frame_start();
    base = int'(out_q.size());
    line(200, 8);
    chk_w("fA_fourth", get_w(base + 3), mk(0,0,0, 0,0,0, 201,202,203));
    base = int'(out_q.size());
    line(210, 8);
    chk_w("fB_fourth", get_w(base + 3), mk(0,0,0, 201,202,203, 211,212,213));
    base = int'(out_q.size());
    line(220, 8);
    chk_w("fC_fourth", get_w(base + 3), mk(201,202,203, 211,212,213, 221,222,223));

    // Over-long line of 10 pixels: all shift, only the first 8 are stored.
    frame_start();
    base = int'(out_q.size());
    line(1, 10);
    chk("long_count", 80'(int'(out_q.size()) - base), 80'd10);
    chk_w("long_last", get_w(base + 9), mk(0,0,0, 0,0,0, 8,9,10));
    base = int'(out_q.size());
    line(50, 8);
    chk_w("after_long_first", get_w(base + 0), mk(0,0,0, 0,0,1, 0,0,50));
    chk_w("after_long_last", get_w(base + 7), mk(0,0,0, 6,7,8, 55,56,57));

    // Reset in the middle of a line: outputs clear at once, row restarts at 0.
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 1'b1, 60 + k);
    rst = 1'b1;
    #1;
    chk("midline_reset", {5'b0, o_HSYNC, o_VSYNC, o_BLANK, cur}, 80'h0);
    cyc(1'b1, 1'b1, 1'b0, 0);
    rst = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 0);
    cyc(1'b1, 1'b1, 1'b0, 0);
    base = int'(out_q.size());
    line(100, 8);
    chk_w("post_reset_l0", get_w(base + 2), mk(0,0,0, 0,0,0, 100,101,102));
    base = int'(out_q.size());
    line(110, 8);
    chk_w("post_reset_l1", get_w(base + 2), mk(0,0,0, 100,101,102, 110,111,112));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
